// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: one shared memory port for core fetch and data.
// Optional: define RISCV_ARB_FAIRNESS_EN to bound fetch starvation.
module riscv_mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instruction_address,
  output logic [31:0] instruction_data,
  output logic        instruction_ready,
  input  logic [31:0] data_address,
  input  logic [1:0]  data_width,
  input  logic [31:0] data_out,
  input  logic        data_read,
  input  logic        data_write,
  output logic [31:0] data_in,
  output logic        data_ready,
  output logic [31:0] mem_address,
  output logic [1:0]  mem_width,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        protocol_error
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  width_q;
  logic        rd_q;
  logic        wr_q;
  logic        data_req;
  logic        fetch_owed;
  logic        grant;
  logic        grant_data;
  logic        done;

  assign data_req = data_read | data_write;

`ifdef RISCV_ARB_FAIRNESS_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1) + 1;
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_q;

  // Count back-to-back data grants; a fetch grant clears the debt.
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_q <= '0;
    end else if (grant_data) begin
      if (starve_q < LIMIT)
        starve_q <= starve_q + CW'(1);
    end else if (grant) begin
      starve_q <= '0;
    end
  end

  assign fetch_owed = (starve_q >= LIMIT);
`else
  assign fetch_owed = 1'b0;
`endif

  // Arbitrate, choose next state and drive core-side responses.
  always_comb begin
    state_next        = state;
    done              = 1'b0;
    grant             = 1'b0;
    grant_data        = 1'b0;
    data_ready        = 1'b0;
    data_in           = '0;
    instruction_ready = 1'b0;
    instruction_data  = '0;
    protocol_error    = 1'b0;
    if (!reset) begin
      done       = (state != IDLE) && mem_ready;
      grant      = (state == IDLE) || mem_ready;
      grant_data = grant && data_req && !fetch_owed;
      unique case (1'b1)
        !grant:     state_next = state;
        grant_data: state_next = DATA;
        default:    state_next = FETCH;
      endcase
      if (done && state == DATA) begin
        data_ready = 1'b1;
        data_in    = mem_rdata;
      end
      if (done && state == FETCH &&
          addr_q == instruction_address) begin
        instruction_ready = 1'b1;
        instruction_data  = mem_rdata;
      end
      protocol_error = grant_data &&
        (data_width == 2'd3 || (data_read && data_write));
    end
  end

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clock) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Latch the winner; the memory port sees only these copies.
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      width_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else if (grant_data) begin
      addr_q  <= data_address;
      wdata_q <= data_out;
      width_q <= (data_width == 2'd3) ? 2'd2 : data_width;
      rd_q    <= !data_write;
      wr_q    <= data_write;
    end else if (grant) begin
      addr_q  <= instruction_address;
      wdata_q <= '0;
      width_q <= 2'd2;
      rd_q    <= 1'b1;
      wr_q    <= 1'b0;
    end
  end

  assign mem_address = addr_q;
  assign mem_width   = width_q;
  assign mem_wdata   = wdata_q;
  assign mem_read    = rd_q;
  assign mem_write   = wr_q;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb_riscv_mem_arbiter: directed scenarios plus random traffic
// checked against a transaction-level model of the arbiter.
module tb_riscv_mem_arbiter;

  localparam int LIMIT = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] instruction_address;
  logic [31:0] instruction_data;
  logic        instruction_ready;
  logic [31:0] data_address;
  logic [1:0]  data_width;
  logic [31:0] data_out;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_in;
  logic        data_ready;
  logic [31:0] mem_address;
  logic [1:0]  mem_width;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        protocol_error;

  int checks = 0;
  int errors = 0;

  riscv_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clock(clock),
    .reset(reset),
    .instruction_address(instruction_address),
    .instruction_data(instruction_data),
    .instruction_ready(instruction_ready),
    .data_address(data_address),
    .data_width(data_width),
    .data_out(data_out),
    .data_read(data_read),
    .data_write(data_write),
    .data_in(data_in),
    .data_ready(data_ready),
    .mem_address(mem_address),
    .mem_width(mem_width),
    .mem_wdata(mem_wdata),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .protocol_error(protocol_error)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask

  // Model: the transaction currently on the memory port.
  typedef struct packed {
    logic        valid;
    logic        is_data;
    logic        write;
    logic [31:0] addr;
    logic [1:0]  width;
    logic [31:0] wdata;
  } txn_t;

  txn_t cur;
  int   starve;
  bit   fair;
  bit   last_dr;

  // Compare outputs with the model, then advance it one clock.
  task automatic go();
    bit fin, grant, dwin, e_dr, e_ir, e_pe;
    fin   = !reset && cur.valid && mem_ready;
    e_dr  = fin && cur.is_data;
    e_ir  = fin && !cur.is_data &&
            cur.addr == instruction_address;
    grant = !reset && (!cur.valid || mem_ready);
    dwin  = grant && (data_read || data_write) &&
            !(fair && starve >= LIMIT);
    e_pe  = dwin && (data_width == 2'd3 ||
                     (data_read && data_write));
    check("m_rd", 64'(mem_read), 64'(cur.valid && !cur.write));
    check("m_wr", 64'(mem_write), 64'(cur.valid && cur.write));
    check("m_addr", 64'(mem_address), 64'(cur.addr));
    check("m_width", 64'(mem_width), 64'(cur.width));
    if (!cur.valid || cur.write)
      check("m_wdata", 64'(mem_wdata), 64'(cur.wdata));
    check("d_rdy", 64'(data_ready), 64'(e_dr));
    check("i_rdy", 64'(instruction_ready), 64'(e_ir));
    check("perr", 64'(protocol_error), 64'(e_pe));
    if (e_dr) check("d_in", 64'(data_in), 64'(mem_rdata));
    if (e_ir)
      check("i_data", 64'(instruction_data), 64'(mem_rdata));
    if (reset) begin
      cur    = '0;
      starve = 0;
    end else if (dwin) begin
      cur.valid   = 1'b1;
      cur.is_data = 1'b1;
      cur.write   = data_write;
      cur.addr    = data_address;
      cur.width   = (data_width == 2'd3) ? 2'd2 : data_width;
      cur.wdata   = data_out;
      starve++;
    end else if (grant) begin
      cur.valid   = 1'b1;
      cur.is_data = 1'b0;
      cur.write   = 1'b0;
      cur.addr    = instruction_address;
      cur.width   = 2'd2;
      cur.wdata   = '0;
      starve      = 0;
    end
    last_dr = e_dr;
    @(negedge clock);
  endtask

  initial begin
    bit          efetch;
    logic [1:0]  r;
`ifdef RISCV_ARB_FAIRNESS_EN
    fair = 1'b1;
`else
    fair = 1'b0;
`endif
    cur     = '0;
    starve  = 0;
    last_dr = 1'b0;
    reset   = 1'b1;
    instruction_address = 32'h100;
    data_address = '0;
    data_width   = '0;
    data_out     = '0;
    data_read    = 1'b0;
    data_write   = 1'b0;
    mem_rdata    = '0;
    mem_ready    = 1'b1;
    repeat (2) @(negedge clock);

    // Reset values
    #1;
    check("rst_mem", {mem_read, mem_write, mem_width, mem_address},
          64'h0);
    check("rst_wdata", 64'(mem_wdata), 64'h0);
    check("rst_out", {instruction_ready, data_ready, protocol_error},
          64'h0);
    check("rst_rd", {data_in, instruction_data}, 64'h0);
    go();

    // Fetch only, zero-wait memory
    reset = 1'b0;
    mem_rdata = 32'hA5A5_0001;
    #1;
    check("idle_rd", 64'(mem_read), 64'h0);
    go();
    mem_rdata = 32'hA5A5_0002;
    #1;
    check("f0_rd", 64'(mem_read), 64'h1);
    check("f0_addr", 64'(mem_address), 64'h100);
    check("f0_irdy", 64'(instruction_ready), 64'h1);
    check("f0_idat", 64'(instruction_data), 64'hA5A5_0002);
    go();
    #1;
    check("f1_irdy", 64'(instruction_ready), 64'h1);
    go();

    // Write with 3 wait states while fetch pends
    data_write   = 1'b1;
    data_address = 32'h2000;
    data_width   = 2'd2;
    data_out     = 32'hDEAD_BEEF;
    #1;
    check("w_grant_perr", 64'(protocol_error), 64'h0);
    go();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("w_hold", {mem_write, mem_width, mem_address},
            {1'b1, 2'd2, 32'h2000});
      check("w_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
      check("w_drdy0", 64'(data_ready), 64'h0);
      go();
    end
    mem_ready  = 1'b1;
    data_write = 1'b0;
    #1;
    check("w_done", {mem_write, data_ready}, 64'h3);
    go();
    #1;
    check("w_then_f", {mem_read, mem_write, mem_address},
          {1'b1, 1'b0, 32'h100});
    go();

    // Continuous data reads against a pending fetch
    data_read    = 1'b1;
    data_address = 32'h3000;
    data_width   = 2'd2;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (i > 0) begin
        efetch = fair && ((i - 1) % 5 == 4);
        check("starve", 64'(mem_address),
              efetch ? 64'h100 : 64'h3000);
      end
      go();
    end
    data_read = 1'b0;
    #1;
    go();
    #1;
    check("drop_f", {mem_read, mem_address}, {1'b1, 32'h100});
    go();

    // Fetch address changes mid-fetch
    instruction_address = 32'h200;
    mem_ready = 1'b0;
    #1;
    check("chg_addr", 64'(mem_address), 64'h100);
    go();
    mem_ready = 1'b1;
    #1;
    check("chg_drop", 64'(instruction_ready), 64'h0);
    go();
    mem_rdata = 32'h1234_5678;
    #1;
    check("chg_addr2", 64'(mem_address), 64'h200);
    check("chg_done", {instruction_ready, instruction_data},
          {1'b1, 32'h1234_5678});
    go();

    // Illegal requests, then reset mid-DATA
    data_read    = 1'b1;
    data_write   = 1'b1;
    data_address = 32'h4000;
    data_out     = 32'h55AA;
    #1;
    check("rw_perr", 64'(protocol_error), 64'h1);
    go();
    mem_ready = 1'b0;
    #1;
    check("rw_wr", {mem_write, mem_read, protocol_error}, 64'h4);
    go();
    mem_ready    = 1'b1;
    data_read    = 1'b0;
    data_width   = 2'd3;
    data_address = 32'h5000;
    #1;
    check("w3_perr", {data_ready, protocol_error}, 64'h3);
    go();
    mem_ready = 1'b0;
    #1;
    check("w3_issue", {mem_write, mem_width, mem_address},
          {1'b1, 2'd2, 32'h5000});
    check("w3_perr0", 64'(protocol_error), 64'h0);
    go();
    reset     = 1'b1;
    mem_ready = 1'b1;
    #1;
    check("rst_mid_rdy", 64'(data_ready), 64'h0);
    go();
    reset      = 1'b0;
    data_write = 1'b0;
    #1;
    check("rst_mid_port", {mem_write, mem_read, data_ready}, 64'h0);
    go();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      reset     = ($urandom_range(0, 299) == 0);
      mem_ready = ($urandom_range(0, 9) < 6);
      mem_rdata = $urandom();
      if ($urandom_range(0, 7) == 0)
        instruction_address = 32'h100 + 32'($urandom_range(0, 3)) * 4;
      if (!(data_read || data_write) || last_dr) begin
        r            = 2'($urandom_range(0, 3));
        data_read    = r[0];
        data_write   = r[1];
        data_address = $urandom();
        data_width   = 2'($urandom_range(0, 3));
        data_out     = $urandom();
      end
      #1;
      go();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
